// File: rtl/stim_bist_pkg.sv
// rtl/stim_bist_pkg.sv - shared state encoding and constants for the stimulus BIST controller
package stim_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam int          MAX_VEC  = 32;

endpackage

// File: rtl/misr_shift.sv
// rtl/misr_shift.sv - single-input shift MISR that compacts the response stream
module misr_shift #(
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = 16'h1021
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_nxt;

  // Shift left, fold the outgoing MSB back through the polynomial, then inject din at bit 0
  always_comb begin
    sig_nxt    = (sig << 1) ^ (sig[MISR_W-1] ? POLY : '0);
    sig_nxt[0] = sig_nxt[0] ^ din;
  end

  // Signature register: reset and clear both zero it, en takes one response bit
  always_ff @(posedge clk) begin
    if (rst || clr) sig <= '0;
    else if (en)    sig <= sig_nxt;
  end

endmodule

// File: rtl/stim_bist_ctrl.sv
// rtl/stim_bist_ctrl.sv - walks N_VEC select/data vectors into a device and signs its responses
module stim_bist_ctrl
  import stim_bist_pkg::*;
#(
  parameter int                STEP_CYCLES = 1,
  parameter int                N_VEC       = 32,
  parameter int                MISR_W      = 16,
  parameter logic [MISR_W-1:0] POLY        = DEF_POLY,
  parameter logic [MISR_W-1:0] GOLDEN      = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              y_in,
  output logic              sel,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic [4:0]        vec_idx,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic              pass
);

  state_t            state;
  logic [4:0]        k;
  logic [7:0]        hc;
  logic              hold_last;
  logic              misr_clr;
  logic              misr_en;
  logic [MISR_W-1:0] sig_final;

  assign hold_last = (hc == 8'(STEP_CYCLES - 1));
  assign misr_clr  = (state == IDLE) && start;
  assign misr_en   = (state == RUN) && hold_last;
  assign vec_idx   = k;

  // Value the MISR takes on the final sample edge, so pass is valid together with done
  always_comb begin
    sig_final    = (signature << 1) ^ (signature[MISR_W-1] ? POLY : '0);
    sig_final[0] = sig_final[0] ^ y_in;
  end

  // Run sequencer: vector index, hold counter and registered stimulus/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      k                 <= '0;
      hc                <= '0;
      {sel, A, B, C, D} <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state             <= RUN;
            k                 <= '0;
            hc                <= '0;
            {sel, A, B, C, D} <= '0;
            busy              <= 1'b1;
          end
        end
        RUN: begin
          if (hold_last) begin
            hc <= '0;
            if (k == 5'(N_VEC - 1)) begin
              // last vector sampled: hold k, raise done for the single DONE cycle
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_final == GOLDEN);
            end else begin
              k                 <= k + 5'd1;
              {sel, A, B, C, D} <= k + 5'd1;
            end
          end else begin
            hc <= hc + 8'd1;
          end
        end
        DONE: begin
          state             <= IDLE;
          done              <= 1'b0;
          k                 <= '0;
          {sel, A, B, C, D} <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  misr_shift #(
    .MISR_W (MISR_W),
    .POLY   (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (y_in),
    .sig (signature)
  );

endmodule

// File: tb/tb_stim_bist_ctrl.sv
// tb/tb_stim_bist_ctrl.sv - directed self-checking bench for stim_bist_ctrl
module tb_stim_bist_ctrl;

  // device under stimulus: a select-steered gate pair
  function automatic logic dev(input logic s, input logic a, input logic b,
                               input logic c, input logic d);
    return s ? (a ^ c) : (b & d);
  endfunction

  // reference signature of the device over all 32 vectors
  function automatic logic [15:0] model_sig();
    logic [15:0] s;
    logic [4:0]  v;
    logic        y;
    s = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      y = dev(v[4], v[3], v[2], v[1], v[0]);
      s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000);
      s[0] = s[0] ^ y;
    end
    return s;
  endfunction

  localparam logic [15:0] G = model_sig();

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic y0 = 1'b0, y1 = 1'b0;
  logic y2;

  logic sel0, a0, b0, c0, d0, busy0, done0, pass0;
  logic sel1, a1, b1, c1, d1, busy1, done1, pass1;
  logic sel2, a2, b2, c2, d2, busy2, done2, pass2;
  logic [4:0]  vi0, vi1, vi2;
  logic [15:0] sg0, sg1, sg2;

  assign y2 = dev(sel2, a2, b2, c2, d2);

  stim_bist_ctrl dut0 (
    .clk(clk), .rst(rst0), .start(start0), .y_in(y0),
    .sel(sel0), .A(a0), .B(b0), .C(c0), .D(d0), .vec_idx(vi0),
    .busy(busy0), .done(done0), .signature(sg0), .pass(pass0));

  stim_bist_ctrl #(.STEP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .y_in(y1),
    .sel(sel1), .A(a1), .B(b1), .C(c1), .D(d1), .vec_idx(vi1),
    .busy(busy1), .done(done1), .signature(sg1), .pass(pass1));

  stim_bist_ctrl #(.GOLDEN(G)) dut2 (
    .clk(clk), .rst(rst1), .start(start2), .y_in(y2),
    .sel(sel2), .A(a2), .B(b2), .C(c2), .D(d2), .vec_idx(vi2),
    .busy(busy2), .done(done2), .signature(sg2), .pass(pass2));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ndone;
  int done_at;
  int found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // reset state
    tick(); tick();
    check("rst_busy0", 32'(busy0), 0);
    check("rst_done0", 32'(done0), 0);
    check("rst_pass0", 32'(pass0), 0);
    check("rst_sig0",  32'(sg0), 0);
    check("rst_out0",  32'({sel0, a0, b0, c0, d0, vi0}), 0);
    check("rst_out1",  32'({busy1, done1, pass1, sg1, vi1}), 0);
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // default run with y_in=0 on dut0 and device-driven dut2; extra starts at cycles 5 and 33
    start0 = 1'b1; start2 = 1'b1;
    tick();
    start0 = 1'b0; start2 = 1'b0;
    cyc = 1; ndone = 0; done_at = 0;
    check("busy_c1", 32'(busy0), 1);
    check("vec_c1",  32'(vi0), 0);
    while (cyc < 40) begin
      if (done0) begin
        ndone++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc == 6)  check("pat_k5",  32'({vi0, sel0, a0, b0, c0, d0}), 32'({5'd5,  1'b0, 4'b0101}));
      if (cyc == 22) check("pat_k21", 32'({vi0, sel0, a0, b0, c0, d0}), 32'({5'd21, 1'b1, 4'b0101}));
      if (cyc == 32) check("pat_k31", 32'({vi0, sel0, a0, b0, c0, d0}), 32'({5'd31, 1'b1, 4'b1111}));
      if (cyc == 33) begin
        check("done0_c33", 32'(done0), 1);
        check("busy0_c33", 32'(busy0), 0);
        check("sig0_zero", 32'(sg0), 0);
        check("pass0",     32'(pass0), 1);
        check("done2_c33", 32'(done2), 1);
        check("sig2_model", 32'(sg2), 32'(G));
        check("pass2",     32'(pass2), 1);
      end
      if (cyc == 35) begin
        check("idle_out0", 32'({sel0, a0, b0, c0, d0, vi0, busy0}), 0);
        check("idle_sig2_hold", 32'(sg2), 32'(G));
        check("idle_pass2_hold", 32'(pass2), 1);
      end
      start0 = (cyc == 5 || cyc == 33);
      tick();
    end
    start0 = 1'b0;
    check("done0_count", 32'(ndone), 1);
    check("done0_cycle", 32'(done_at), 33);

    // STEP_CYCLES=3: response driven wrong except on the third hold cycle
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1; ndone = 0; done_at = 0;
    while (cyc < 100) begin
      if (cyc <= 96) begin
        check("hold3_vec", 32'(vi1), 32'((cyc - 1) / 3));
        y1 = (((cyc - 1) % 3) == 2) ? dev(sel1, a1, b1, c1, d1) : ~dev(sel1, a1, b1, c1, d1);
      end else begin
        y1 = 1'b0;
      end
      if (done1) begin
        ndone++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc == 97) begin
        check("hold3_sig",  32'(sg1), 32'(G));
        check("hold3_pass", 32'(pass1), 32'(G == 16'h0000));
      end
      tick();
    end
    check("hold3_done_count", 32'(ndone), 1);
    check("hold3_done_cycle", 32'(done_at), 97);

    // reset mid-run at vec_idx 10, responses forced to 1 so the signature is nonzero
    y0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (vi0 == 5'd10) begin
        found = 1;
        break;
      end
      tick();
    end
    check("abort_reach_k10", 32'(found), 1);
    check("abort_sig_nonzero", 32'(sg0 != 16'h0000), 1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    y0 = 1'b0;
    check("abort_busy", 32'(busy0), 0);
    check("abort_sig",  32'(sg0), 0);
    check("abort_out",  32'({sel0, a0, b0, c0, d0, vi0, done0, pass0}), 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0) ndone++;
      tick();
    end
    check("abort_no_done", 32'(ndone), 0);

    // full run after the abort
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1; ndone = 0; done_at = 0;
    while (cyc < 40) begin
      if (done0) begin
        ndone++;
        if (done_at == 0) done_at = cyc;
      end
      tick();
    end
    check("rerun_done_count", 32'(ndone), 1);
    check("rerun_done_cycle", 32'(done_at), 33);
    check("rerun_sig", 32'(sg0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
